// File: rtl/countdown_pkg.sv
// Shared types and limits for the BCD mm:ss.cc countdown timer.
// Optional autoreload behaviour is selected by COUNTDOWN_AUTORELOAD_EN in countdown_timer.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [3:0] DIGIT_MAX            = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX         = 4'd5;
  localparam int         ALARM_CYCLES_DEFAULT = 200;

  function automatic logic preset_ok(input logic [3:0] cd, input logic [3:0] cg,
                                     input logic [3:0] sd, input logic [3:0] sg,
                                     input logic [3:0] md, input logic [3:0] mg);
    return (cd <= DIGIT_MAX) && (cg <= DIGIT_MAX) && (sd <= DIGIT_MAX) &&
           (sg <= SEC_TENS_MAX) && (md <= DIGIT_MAX) && (mg <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/countdown_timer_digit.sv
// One BCD down-counting digit that wraps 0 -> MAX and signals a borrow to the next digit.
// Priority: reset, then load, then decrement.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       borrow_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (dec_en) begin
      q <= (q == 4'd0) ? MAX : q - 4'd1;
    end
  end

  assign borrow_out = dec_en && (q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss.cc countdown timer: preset load with validation, run/pause FSM, done pulse, timed alarm.
// Define COUNTDOWN_AUTORELOAD_EN to reload the preset on expiry and keep running.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int ALARM_CYCLES = ALARM_CYCLES_DEFAULT
) (
  input  logic       CLK_100Hz,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] pre_ms_d,
  input  logic [3:0] pre_ms_g,
  input  logic [3:0] pre_second_d,
  input  logic [3:0] pre_second_g,
  input  logic [3:0] pre_minute_d,
  input  logic [3:0] pre_minute_g,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] ms_d,
  output logic [3:0] ms_g,
  output logic [3:0] second_d,
  output logic [3:0] second_g,
  output logic [3:0] minute_d,
  output logic [3:0] minute_g,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  state_t      state, state_nxt;
  logic [3:0]  dig      [6];
  logic [3:0]  pre_in   [6];
  logic [3:0]  preset_q [6];
  logic [3:0]  ld_val   [6];
  logic [6:0]  chain;
  logic        count_zero, count_one;
  logic        pre_valid, load_acc, reload, dec, done_nxt, load_err_nxt, alarm_clr;
  logic [15:0] alarm_cnt;

  assign pre_in[0] = pre_ms_d;
  assign pre_in[1] = pre_ms_g;
  assign pre_in[2] = pre_second_d;
  assign pre_in[3] = pre_second_g;
  assign pre_in[4] = pre_minute_d;
  assign pre_in[5] = pre_minute_g;

  assign pre_valid  = preset_ok(pre_ms_d, pre_ms_g, pre_second_d, pre_second_g,
                                pre_minute_d, pre_minute_g);
  assign count_zero = (dig[0] == 4'd0) && (dig[1] == 4'd0) && (dig[2] == 4'd0) &&
                      (dig[3] == 4'd0) && (dig[4] == 4'd0) && (dig[5] == 4'd0);
  assign count_one  = (dig[0] == 4'd1) && (dig[1] == 4'd0) && (dig[2] == 4'd0) &&
                      (dig[3] == 4'd0) && (dig[4] == 4'd0) && (dig[5] == 4'd0);

  always_comb begin
    state_nxt    = state;
    load_acc     = 1'b0;
    load_err_nxt = 1'b0;
    reload       = 1'b0;
    dec          = 1'b0;
    done_nxt     = 1'b0;
    unique case (state)
      RUN: begin
        if (stop) begin
          state_nxt = PAUSE;
        end else if (count_zero) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
          reload = 1'b1;
`endif
        end else begin
          dec = 1'b1;
          if (count_one) begin
            done_nxt = 1'b1;
`ifndef COUNTDOWN_AUTORELOAD_EN
            state_nxt = DONE;
`endif
          end
        end
      end
      default: begin
        // A same-cycle load takes priority over start.
        if (load) begin
          if (pre_valid) begin
            load_acc  = 1'b1;
            state_nxt = IDLE;
          end else begin
            load_err_nxt = 1'b1;
          end
        end else if (start && !stop && state != DONE && !count_zero) begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  assign alarm_clr = load_acc && (state == DONE);

  always_ff @(posedge CLK_100Hz) begin
    if (reset) begin
      state    <= IDLE;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
      for (int i = 0; i < 6; i++) preset_q[i] <= 4'd0;
    end else begin
      state    <= state_nxt;
      running  <= (state_nxt == RUN);
      done     <= done_nxt;
      load_err <= load_err_nxt;
      if (load_acc) begin
        for (int i = 0; i < 6; i++) preset_q[i] <= pre_in[i];
      end
    end
  end

  always_ff @(posedge CLK_100Hz) begin
    if (reset) begin
      alarm     <= 1'b0;
      alarm_cnt <= 16'd0;
    end else if (done_nxt) begin
      alarm     <= 1'b1;
      alarm_cnt <= 16'(ALARM_CYCLES - 1);
    end else if (alarm_clr) begin
      alarm     <= 1'b0;
      alarm_cnt <= 16'd0;
    end else if (alarm) begin
      if (alarm_cnt == 16'd0) alarm <= 1'b0;
      else                    alarm_cnt <= alarm_cnt - 16'd1;
    end
  end

  assign chain[0] = dec;

  for (genvar i = 0; i < 6; i++) begin : g_digit
    assign ld_val[i] = load_acc ? pre_in[i] : preset_q[i];
    bcd_down_digit #(
      .MAX ((i == 3) ? SEC_TENS_MAX : DIGIT_MAX)
    ) u_digit (
      .clk        (CLK_100Hz),
      .reset      (reset),
      .dec_en     (chain[i]),
      .load       (load_acc || reload),
      .load_val   (ld_val[i]),
      .q          (dig[i]),
      .borrow_out (chain[i+1])
    );
  end

  // minute_g cannot borrow: RUN only decrements a nonzero count.
  logic unused_top_borrow;
  assign unused_top_borrow = chain[6];

  assign ms_d     = dig[0];
  assign ms_g     = dig[1];
  assign second_d = dig[2];
  assign second_g = dig[3];
  assign minute_d = dig[4];
  assign minute_g = dig[5];

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: integer-centisecond model checked every cycle plus directed literal checks.
// Build with COUNTDOWN_AUTORELOAD_EN defined to exercise the autoreload sequence instead of DONE.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int ALARM = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [23:0] pre = 24'h0;
  logic [3:0]  ms_d, ms_g, second_d, second_g, minute_d, minute_g;
  logic        running, done, alarm, load_err;
  logic [23:0] disp;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  countdown_timer #(.ALARM_CYCLES(ALARM)) dut (
    .CLK_100Hz    (clk),
    .reset        (reset),
    .load         (load),
    .pre_ms_d     (pre[3:0]),
    .pre_ms_g     (pre[7:4]),
    .pre_second_d (pre[11:8]),
    .pre_second_g (pre[15:12]),
    .pre_minute_d (pre[19:16]),
    .pre_minute_g (pre[23:20]),
    .start        (start),
    .stop         (stop),
    .ms_d         (ms_d),
    .ms_g         (ms_g),
    .second_d     (second_d),
    .second_g     (second_g),
    .minute_d     (minute_d),
    .minute_g     (minute_g),
    .running      (running),
    .done         (done),
    .alarm        (alarm),
    .load_err     (load_err)
  );

  assign disp = {minute_g, minute_d, second_g, second_d, ms_g, ms_d};

  always #5 clk = ~clk;

  function automatic bit bcd_valid(input logic [23:0] v);
    for (int i = 0; i < 6; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return v[15:12] <= 4'd5;
  endfunction

  function automatic int to_cs(input logic [23:0] v);
    int m, s, c;
    m = int'(v[23:20]) * 10 + int'(v[19:16]);
    s = int'(v[15:12]) * 10 + int'(v[11:8]);
    c = int'(v[7:4]) * 10 + int'(v[3:0]);
    return (m * 60 + s) * 100 + c;
  endfunction

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    c = cs % 100;
    s = (cs / 100) % 60;
    m = cs / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: count and preset as plain centiseconds; alarm as clocks remaining.
  int m_cnt = 0, m_pre = 0, m_alarm_left = 0;
  bit m_run = 0, m_expired = 0, m_done = 0, m_lerr = 0;

  always @(posedge clk) begin
    m_done = 0;
    m_lerr = 0;
    if (reset) begin
      m_cnt = 0; m_pre = 0; m_alarm_left = 0; m_run = 0; m_expired = 0;
    end else begin
      if (m_alarm_left > 0) m_alarm_left--;
      if (m_run) begin
        if (stop) m_run = 0;
        else if (m_cnt == 0) m_cnt = m_pre;
        else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_done = 1;
            m_alarm_left = ALARM;
            if (!AUTO) begin m_run = 0; m_expired = 1; end
          end
        end
      end else if (load) begin
        if (bcd_valid(pre)) begin
          m_pre = to_cs(pre);
          m_cnt = m_pre;
          if (m_expired) m_alarm_left = 0;
          m_expired = 0;
        end else m_lerr = 1;
      end else if (start && !stop && !m_expired && m_cnt != 0) m_run = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_digits",   32'(disp),     32'(to_bcd(m_cnt)));
      chk("model_running",  32'(running),  32'(m_run));
      chk("model_done",     32'(done),     32'(m_done));
      chk("model_alarm",    32'(alarm),    32'(m_alarm_left > 0));
      chk("model_load_err", 32'(load_err), 32'(m_lerr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] v);
    pre = v; load = 1'b1; tick(1); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    tick(2);
    chk_en = 1'b1;
    chk("rst_digits", 32'(disp), 32'h0);
    chk("rst_flags", {28'h0, running, done, alarm, load_err}, 32'h0);
    reset = 1'b0;

    // Full borrow chain, second_g wraps to 5.
    do_load(24'h010000);
    chk("load_latency", 32'(disp), 32'h010000);
    do_start();
    chk("start_running", 32'(running), 32'h1);
    chk("start_no_dec", 32'(disp), 32'h010000);
    tick(1);
    chk("borrow_all", 32'(disp), 32'h005999);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("stop_freeze", 32'(disp), 32'h005999);
    chk("stop_running", 32'(running), 32'h0);

    // Pause and resume.
    do_load(24'h001000);
    do_start();
    tick(30);
    chk("run30", 32'(disp), 32'h000970);
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(3);
    chk("paused_hold", 32'(disp), 32'h000970);
    do_start();
    chk("resume_no_dec", 32'(disp), 32'h000970);
    tick(1);
    chk("resume_dec", 32'(disp), 32'h000969);
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    chk("start_stop_pause", 32'(running), 32'h0);
    chk("start_stop_hold", 32'(disp), 32'h000969);

    // Rejected loads, and a load ignored while running.
    do_load(24'h006000);
    chk("err_sec_tens", 32'(load_err), 32'h1);
    chk("err_sec_tens_hold", 32'(disp), 32'h000969);
    tick(1);
    chk("err_one_cycle", 32'(load_err), 32'h0);
    do_load(24'h00000A);
    chk("err_digit_a", 32'(load_err), 32'h1);
    chk("err_digit_a_hold", 32'(disp), 32'h000969);
    do_start();
    do_load(24'h000100);
    chk("run_load_ignored", 32'(disp), 32'h000968);
    chk("run_load_no_err", 32'(load_err), 32'h0);

    // Reset mid-run, then start with a zero count.
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("midrun_rst_digits", 32'(disp), 32'h0);
    chk("midrun_rst_running", 32'(running), 32'h0);
    do_start();
    chk("zero_start_ignored", 32'(running), 32'h0);

`ifdef COUNTDOWN_AUTORELOAD_EN
    begin
      logic [23:0] seq_d [8] = '{24'h2, 24'h1, 24'h0, 24'h3, 24'h2, 24'h1, 24'h0, 24'h3};
      logic        seq_p [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_load(24'h000003);
      do_start();
      for (int i = 0; i < 8; i++) begin
        tick(1);
        chk($sformatf("auto_digits_%0d", i), 32'(disp), 32'(seq_d[i]));
        chk($sformatf("auto_done_%0d", i), 32'(done), 32'(seq_p[i]));
        chk($sformatf("auto_running_%0d", i), 32'(running), 32'h1);
      end
      stop = 1'b1; tick(1); stop = 1'b0;
      chk("auto_stop", 32'(running), 32'h0);
      tick(ALARM);
    end
`else
    // Basic expiry and the alarm window.
    do_load(24'h000005);
    do_start();
    for (int i = 4; i >= 1; i--) begin
      tick(1);
      chk($sformatf("step_%0d", i), 32'(disp), 32'(i));
    end
    tick(1);
    chk("expire_digits", 32'(disp), 32'h0);
    chk("expire_done", 32'(done), 32'h1);
    chk("expire_alarm", 32'(alarm), 32'h1);
    chk("expire_running", 32'(running), 32'h0);
    tick(199);
    chk("alarm_last", 32'(alarm), 32'h1);
    tick(1);
    chk("alarm_off", 32'(alarm), 32'h0);
    do_start();
    chk("done_start_ignored", 32'(running), 32'h0);

    // Reset mid-alarm.
    do_load(24'h000002);
    do_start();
    tick(12);
    chk("midalarm_alarm", 32'(alarm), 32'h1);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("midalarm_rst", 32'(alarm), 32'h0);
    tick(5);
    chk("midalarm_stays_off", 32'(alarm), 32'h0);

    // Valid load in DONE clears the alarm and returns to IDLE.
    do_load(24'h000001);
    do_start();
    tick(1);
    chk("one_cs_done", 32'(done), 32'h1);
    tick(3);
    do_load(24'h000007);
    chk("done_load_alarm", 32'(alarm), 32'h0);
    chk("done_load_digits", 32'(disp), 32'h000007);
    do_start();
    chk("done_load_restart", 32'(running), 32'h1);
    tick(3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
